// File: rtl/fu_div_ctrl.sv
// Divider sharing controller: round-robin issue to a single divider,
// result held on a CDB request until granted; flush drains and discards.
module fu_div_ctrl #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*TAG_W-1:0]  req_tag,
    output logic [N_REQ-1:0]        grant,
    output logic                    div_en,
    output logic [DATA_W-1:0]       div_a,
    output logic [DATA_W-1:0]       div_b,
    input  logic [DATA_W-1:0]       div_res,
    input  logic                    div_finish,
    input  logic                    flush,
    output logic                    cdb_req,
    input  logic                    cdb_gnt,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic                    busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        BCAST
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   rr_q;
    logic [PTR_W-1:0]   rr_d;
    logic [PTR_W-1:0]   win;
    logic               found;
    logic               take;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  data_q;
    logic [TAG_W-1:0]   tag_q;

    // First requester at or after rr_q, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(rr_q) + k) % N_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(rr_q) + k) % N_REQ);
            end
        end
        rr_d = PTR_W'((int'(win) + 1) % N_REQ);
    end

    always_comb begin
        state_d = state_q;
        grant   = '0;
        take    = 1'b0;
        div_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found && !flush) begin
                    grant[win] = 1'b1;
                    take       = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                div_en  = 1'b1;
                state_d = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_d = div_finish ? IDLE : DRAIN;
                end else if (div_finish) begin
                    state_d = BCAST;
                end
            end
            DRAIN: begin
                if (div_finish) begin
                    state_d = IDLE;
                end
            end
            BCAST: begin
                if (flush || cdb_gnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                rr_q  <= rr_d;
                a_q   <= req_a[int'(win)*DATA_W +: DATA_W];
                b_q   <= req_b[int'(win)*DATA_W +: DATA_W];
                tag_q <= req_tag[int'(win)*TAG_W +: TAG_W];
            end
            if (state_q == WAIT && div_finish && !flush) begin
                data_q <= div_res;
            end
        end
    end

    assign div_a    = a_q;
    assign div_b    = b_q;
    assign cdb_data = data_q;
    assign cdb_tag  = tag_q;
    assign cdb_req  = (state_q == BCAST);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fu_div_ctrl.sv
// Randomized bench for fu_div_ctrl against a transaction-level model
// of the sharing protocol plus a behavioural divider.
module tb_fu_div_ctrl;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N*TW-1:0] req_tag = '0;
    logic [N-1:0]    grant;
    logic            div_en;
    logic [DW-1:0]   div_a;
    logic [DW-1:0]   div_b;
    logic [DW-1:0]   div_res = '0;
    logic            div_finish = 1'b0;
    logic            flush = 1'b0;
    logic            cdb_req;
    logic            cdb_gnt = 1'b0;
    logic [DW-1:0]   cdb_data;
    logic [TW-1:0]   cdb_tag;
    logic            busy;

    fu_div_ctrl #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a),
        .req_b(req_b), .req_tag(req_tag), .grant(grant),
        .div_en(div_en), .div_a(div_a), .div_b(div_b),
        .div_res(div_res), .div_finish(div_finish), .flush(flush),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_data(cdb_data),
        .cdb_tag(cdb_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of the controller at the transaction level.
    int            mptr = 0;
    bit            m_busy, m_en, m_sq, m_res;
    logic [DW-1:0] m_a, m_b, m_q;
    logic [TW-1:0] m_tag;
    // Behavioural divider.
    int            dcnt = 0;
    logic [DW-1:0] d_q;
    // Stimulus knobs.
    int            p_flush = 0, p_gnt = 100, p_spur = 0, p_new = 0;
    logic [N-1:0]  hold = '0;
    int            drop = -1;
    int            gq[$];
    int            bcasts = 0;

    function automatic logic [DW-1:0] newb();
        return ($urandom_range(9) == 0) ? '0 : DW'($urandom_range(1, 5000));
    endfunction

    task automatic cycle();
        logic [N-1:0] eg;
        int w;
        @(negedge clk);
        if (drop >= 0) req[drop] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!req[i] && i != drop &&
                (hold[i] || $urandom_range(99) < p_new)) begin
                req[i] = 1'b1;
                req_a[i*DW +: DW] = $urandom;
                req_b[i*DW +: DW] = newb();
                req_tag[i*TW +: TW] = TW'($urandom);
            end
        end
        drop = -1;
        div_finish = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                div_finish = 1'b1;
                div_res = d_q;
            end
        end else if ($urandom_range(99) < p_spur) begin
            div_finish = 1'b1;
            div_res = $urandom;
        end
        flush = ($urandom_range(99) < p_flush);
        cdb_gnt = ($urandom_range(99) < p_gnt);
        #1;
        eg = '0;
        w = -1;
        if (!m_busy && |req && !flush) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(mptr + k) % N]) w = (mptr + k) % N;
            eg[w] = 1'b1;
        end
        chk("grant", grant, eg);
        chk("busy", busy, m_busy);
        chk("div_en", div_en, m_en);
        chk("cdb_req", cdb_req, m_res);
        if (m_en) begin
            chk("div_a", div_a, m_a);
            chk("div_b", div_b, m_b);
        end
        if (m_res) begin
            chk("cdb_data", cdb_data, m_q);
            chk("cdb_tag", cdb_tag, m_tag);
        end
        if (w >= 0) begin
            m_busy = 1; m_en = 1; m_sq = 0;
            m_a = req_a[w*DW +: DW];
            m_b = req_b[w*DW +: DW];
            m_tag = req_tag[w*TW +: TW];
            mptr = (w + 1) % N;
            drop = w;
            gq.push_back(w);
        end else if (m_en) begin
            m_en = 0;
            if (flush) m_sq = 1;
            dcnt = $urandom_range(1, 4);
            d_q = (m_b == 0) ? '1 : m_a / m_b;
        end else if (m_busy && !m_res) begin
            if (div_finish) begin
                if (m_sq || flush) m_busy = 0;
                else begin m_res = 1; m_q = div_res; end
            end else if (flush) m_sq = 1;
        end else if (m_res && (flush || cdb_gnt)) begin
            m_res = 0;
            m_busy = 0;
            if (!flush) bcasts++;
        end
    endtask

    task automatic do_reset(bit check_outs);
        @(negedge clk);
        #2;
        req = '0;
        flush = 1'b0;
        cdb_gnt = 1'b0;
        div_finish = 1'b0;
        rst_n = 1'b0;
        #1;
        if (check_outs) begin
            chk("rst_grant", grant, 0);
            chk("rst_div_en", div_en, 0);
            chk("rst_cdb_req", cdb_req, 0);
            chk("rst_busy", busy, 0);
            chk("rst_div_a", div_a, 0);
            chk("rst_div_b", div_b, 0);
            chk("rst_cdb_data", cdb_data, 0);
            chk("rst_cdb_tag", cdb_tag, 0);
        end
        mptr = 0; m_busy = 0; m_en = 0; m_sq = 0; m_res = 0;
        dcnt = 0; drop = -1; hold = '0; p_new = 0;
        gq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_grants(int n, int budget);
        int c = 0;
        while (gq.size() < n && c < budget) begin
            cycle();
            c++;
        end
        chk("grant_count", gq.size(), n);
    endtask

    initial begin
        int n;
        int exp_a[4];
        do_reset(1);
        // Single divide 100/7 with tag 5, CDB held off for a while.
        p_gnt = 0;
        req_a[DW-1:0] = 100;
        req_b[DW-1:0] = 7;
        req_tag[TW-1:0] = 5;
        req = 4'b0001;
        n = 0;
        do begin cycle(); n++; end while (!cdb_req && n < 20);
        chk("t1_cdb_req", cdb_req, 1);
        chk("t1_cdb_data", cdb_data, 14);
        chk("t1_cdb_tag", cdb_tag, 5);
        hold = 4'b1111;
        repeat (3) cycle();
        chk("t3_held_data", cdb_data, 14);
        p_gnt = 100;
        cycle();
        cycle();
        chk("t3_regrant", grant, 4'b0010);
        // Randomized traffic with flushes and stray finishes.
        hold = '0; p_new = 30; p_flush = 8; p_gnt = 40; p_spur = 10;
        repeat (3000) cycle();
        chk("bcast_seen", (bcasts > 20), 1);
        // Asynchronous reset while the divider is running.
        n = 0;
        while (!(m_busy && !m_en && !m_res && dcnt > 1) && n < 500) begin
            cycle();
            n++;
        end
        chk("reach_wait", (n < 500), 1);
        do_reset(1);
        p_flush = 0; p_spur = 0; p_gnt = 100;
        hold = 4'b1111;
        run_grants(4, 100);
        exp_a = '{0, 1, 2, 3};
        if (gq.size() >= 4)
            for (int i = 0; i < 4; i++) chk("rr_1111", gq[i], exp_a[i]);
        do_reset(0);
        hold = 4'b1010;
        run_grants(4, 100);
        exp_a = '{1, 3, 1, 3};
        if (gq.size() >= 4)
            for (int i = 0; i < 4; i++) chk("rr_1010", gq[i], exp_a[i]);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
